// File: rtl/obstacle_avoid_ctrl_pkg.sv
// Shared types and constants for the obstacle avoidance controller.
package obstacle_avoid_ctrl_pkg;

    localparam int unsigned DIST_W = 20;
    localparam int unsigned SUM_W  = 22;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_STOP = 2'b00;
    localparam cmd_t CMD_FWD  = 2'b01;
    localparam cmd_t CMD_REV  = 2'b10;
    localparam cmd_t CMD_TURN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_BACK,
        ST_TURN,
        ST_CHECK,
        ST_FAULT
    } state_t;

    // Motion command driven while the FSM sits in a given state.
    function automatic cmd_t state_cmd(input state_t s);
        case (s)
            ST_FWD:  return CMD_FWD;
            ST_BACK: return CMD_REV;
            ST_TURN: return CMD_TURN;
            default: return CMD_STOP;
        endcase
    endfunction

endpackage

// File: rtl/obstacle_avoid_ctrl_dist_filter.sv
// Distance front end: ms prescaler, periodic sampling, validation,
// 4-sample moving average and consecutive-invalid fault detection.
module obstacle_avoid_ctrl_dist_filter
    import obstacle_avoid_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned SAMPLE_MS = 60,
    parameter int unsigned MAX_VALID = 400000,
    parameter int unsigned FAULT_CNT = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DIST_W-1:0] dist_i,
    output logic [DIST_W-1:0] dist_avg,
    output logic              avg_valid,
    output logic              sensor_fault,
    output logic              ms_tick
);

    localparam int unsigned       MS_DIV = CLK_FREQ / 1000;
    localparam logic [DIST_W-1:0] MAX_V  = DIST_W'(MAX_VALID);

    logic [31:0]       ms_cnt;
    logic [31:0]       samp_cnt;
    logic [31:0]       inv_cnt;
    logic [2:0]        fill;
    logic [DIST_W-1:0] win0;
    logic [DIST_W-1:0] win1;
    logic [DIST_W-1:0] win2;
    logic              sample_tick;
    logic              sample_ok;
    logic [SUM_W-1:0]  new_sum;

    // Millisecond prescaler; ms_tick is a registered one-cycle pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b0;
        end else if (ms_cnt == MS_DIV - 1) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b1;
        end else begin
            ms_cnt  <= ms_cnt + 32'd1;
            ms_tick <= 1'b0;
        end
    end

    // Counts ms ticks to place a sample every SAMPLE_MS milliseconds.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            samp_cnt <= '0;
        end else if (ms_tick) begin
            if (samp_cnt == SAMPLE_MS - 1) begin
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + 32'd1;
            end
        end
    end

    // Sample strobe, reading validity and the sum including the incoming reading.
    always_comb begin
        sample_tick = ms_tick && (samp_cnt == SAMPLE_MS - 1);
        sample_ok   = (dist_i != '0) && (dist_i <= MAX_V);
        new_sum     = SUM_W'(dist_i) + SUM_W'(win0) + SUM_W'(win1) + SUM_W'(win2);
    end

    // Window shift, averaging and fault counting on each sample.
    // Only the three previous readings are stored: the fourth window entry
    // is the reading being captured, so the average registers in the same
    // edge that shifts the window.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            win0         <= '0;
            win1         <= '0;
            win2         <= '0;
            fill         <= '0;
            inv_cnt      <= '0;
            sensor_fault <= 1'b0;
            dist_avg     <= '0;
            avg_valid    <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (sample_tick) begin
                if (sample_ok) begin
                    win0         <= dist_i;
                    win1         <= win0;
                    win2         <= win1;
                    inv_cnt      <= '0;
                    sensor_fault <= 1'b0;
                    if (fill != 3'd4) begin
                        fill <= fill + 3'd1;
                    end
                    if (fill >= 3'd3) begin
                        dist_avg  <= new_sum[SUM_W-1:2];
                        avg_valid <= 1'b1;
                    end
                end else begin
                    if (inv_cnt != FAULT_CNT) begin
                        inv_cnt <= inv_cnt + 32'd1;
                    end
                    if ((inv_cnt + 32'd1) >= FAULT_CNT) begin
                        sensor_fault <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/obstacle_avoid_ctrl.sv
// Obstacle avoidance controller: filtered distance, hysteresis obstacle
// flag and a timed reverse/turn/check avoidance state machine.
module obstacle_avoid_ctrl
    import obstacle_avoid_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned SAMPLE_MS = 60,
    parameter int unsigned NEAR_TH   = 20000,
    parameter int unsigned FAR_TH    = 30000,
    parameter int unsigned MAX_VALID = 400000,
    parameter int unsigned FAULT_CNT = 8,
    parameter int unsigned BACK_MS   = 400,
    parameter int unsigned TURN_MS   = 600
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              en,
    input  logic [DIST_W-1:0] dist_i,
    output logic [1:0]        cmd,
    output logic              obstacle,
    output logic [DIST_W-1:0] dist_avg,
    output logic              avg_valid,
    output logic              sensor_fault
);

    localparam logic [DIST_W-1:0] NEAR_V = DIST_W'(NEAR_TH);
    localparam logic [DIST_W-1:0] FAR_V  = DIST_W'(FAR_TH);

    logic        ms_tick;
    logic        eval_done;
    logic [31:0] timer;
    state_t      state;

    obstacle_avoid_ctrl_dist_filter #(
        .CLK_FREQ  (CLK_FREQ),
        .SAMPLE_MS (SAMPLE_MS),
        .MAX_VALID (MAX_VALID),
        .FAULT_CNT (FAULT_CNT)
    ) u_dist_filter (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .dist_i       (dist_i),
        .dist_avg     (dist_avg),
        .avg_valid    (avg_valid),
        .sensor_fault (sensor_fault),
        .ms_tick      (ms_tick)
    );

    // Hysteresis on each fresh average; eval_done marks the updated flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            obstacle  <= 1'b0;
            eval_done <= 1'b0;
        end else begin
            eval_done <= avg_valid;
            if (avg_valid) begin
                if (dist_avg < NEAR_V) begin
                    obstacle <= 1'b1;
                end else if (dist_avg > FAR_V) begin
                    obstacle <= 1'b0;
                end
            end
        end
    end

    // Avoidance FSM with ms timer; cmd is a registered decode of the state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
            timer <= '0;
            cmd   <= CMD_STOP;
        end else begin
            cmd <= state_cmd(state);
            if (!en) begin
                state <= ST_IDLE;
                timer <= '0;
            end else if (sensor_fault) begin
                state <= ST_FAULT;
                timer <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_FWD;
                    end
                    ST_FWD: begin
                        if (obstacle) begin
                            state <= ST_BACK;
                            timer <= BACK_MS;
                        end
                    end
                    ST_BACK: begin
                        if (ms_tick) begin
                            if (timer <= 32'd1) begin
                                state <= ST_TURN;
                                timer <= TURN_MS;
                            end else begin
                                timer <= timer - 32'd1;
                            end
                        end
                    end
                    ST_TURN: begin
                        if (ms_tick) begin
                            if (timer <= 32'd1) begin
                                state <= ST_CHECK;
                                timer <= '0;
                            end else begin
                                timer <= timer - 32'd1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (eval_done) begin
                            if (obstacle) begin
                                state <= ST_TURN;
                                timer <= TURN_MS;
                            end else begin
                                state <= ST_FWD;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule
